// File: rtl/renode_pkg.sv
// Shared types for the Renode co-simulation bridge.
// Action codes, message field widths and the packed message layout.
package renode_pkg;

  localparam int ACTION_WIDTH  = 8;
  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 64;

  typedef enum logic [ACTION_WIDTH-1:0] {
    ACTION_INVALID    = 8'd0,
    ACTION_TICK_CLOCK = 8'd1,
    ACTION_WRITE_REQ  = 8'd2,
    ACTION_READ_REQ   = 8'd3,
    ACTION_RESET      = 8'd4,
    ACTION_LOG        = 8'd5,
    ACTION_INTERRUPT  = 8'd6,
    ACTION_DISCONNECT = 8'd7
  } action_e;

  typedef logic [ADDRESS_WIDTH-1:0] address_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;

  typedef struct packed {
    action_e  action;
    address_t address;
    data_t    data;
  } message_t;

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/renode_interrupts_if.sv
// Valid/ready message port toward the connection arbiter.
// master drives valid/action/address/data, slave drives ready.
interface renode_interrupts_if;
  import renode_pkg::*;

  logic     valid;
  logic     ready;
  action_e  action;
  address_t address;
  data_t    data;

  modport master (
    output valid, action, address, data,
    input  ready
  );

  modport slave (
    input  valid, action, address, data,
    output ready
  );

endinterface

// File: rtl/renode_prio_enc.sv
// Lowest-set-bit priority encoder.
// req: request vector; idx: lowest set index; any: some bit set.
module renode_prio_enc #(
  parameter int N  = 1,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk downward so the lowest set bit is the last write.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/renode_interrupts.sv
// Turns interrupt level changes into Renode "interrupt" messages.
// clk/rst_n, interrupts[N] levels in, msg master port out.
module renode_interrupts
  import renode_pkg::*;
#(
  parameter int InterruptsCount = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [InterruptsCount-1:0] interrupts,
  renode_interrupts_if.master        msg
);

  localparam int N  = InterruptsCount;
  localparam int IW = idx_width(N);

  typedef enum logic {IDLE, SEND} state_e;

  state_e         state;
  state_e         state_nx;
  logic [N-1:0]   sampled;
  logic [N-1:0]   reported;
  logic [N-1:0]   inflight;
  logic [N-1:0]   pending;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  pick;
  logic           level;
  logic           any;
  logic           load;
  logic           accept;
  message_t       out_msg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sampled <= '0;
    else        sampled <= interrupts;
  end

  always_comb begin
    inflight = '0;
    if (state == SEND) inflight[idx] = 1'b1;
  end

  assign pending = (sampled ^ reported) & ~inflight;

  renode_prio_enc #(
    .N  (N),
    .IW (IW)
  ) u_prio (
    .req (pending),
    .idx (pick),
    .any (any)
  );

  assign load   = (state == IDLE) && any;
  assign accept = (state == SEND) && msg.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any)       state_nx = SEND;
      SEND: if (msg.ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      level <= 1'b0;
    end else if (load) begin
      idx   <= pick;
      level <= sampled[pick];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      reported      <= '0;
    else if (accept) reported[idx] <= level;
  end

  always_comb begin
    out_msg         = '0;
    out_msg.action  = ACTION_INTERRUPT;
    out_msg.address = ADDRESS_WIDTH'(idx);
    out_msg.data    = DATA_WIDTH'(level);
    msg.valid       = (state == SEND);
    msg.action      = out_msg.action;
    msg.address     = out_msg.address;
    msg.data        = out_msg.data;
  end

endmodule

// File: tb/tb_renode_interrupts.sv
// Scoreboard bench for renode_interrupts with 4 lines.
// Reference model predicts messages; monitor pops on handshakes.
module tb_renode_interrupts;
  import renode_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] interrupts = '0;

  renode_interrupts_if bus ();

  renode_interrupts #(
    .InterruptsCount (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .interrupts (interrupts),
    .msg        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int line;
    int lvl;
  } exp_t;

  exp_t q[$];
  int   log_q[$];

  // Reference model: per-line "last level Renode knows" and a single
  // in-flight slot. A line needs reporting when the level seen one
  // cycle ago differs from what Renode knows.
  int  m_seen[N];
  int  m_known[N];
  bit  m_busy = 0;
  int  m_line = 0;
  int  m_lvl  = 0;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_seen[i]  = 0;
      m_known[i] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_seen[i]  = 0;
        m_known[i] = 0;
      end
      m_busy = 0;
      q.delete();
    end else begin
      if (m_busy) begin
        if (bus.ready) begin
          m_known[m_line] = m_lvl;
          m_busy = 0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!m_busy && m_seen[i] != m_known[i]) begin
            m_busy = 1;
            m_line = i;
            m_lvl  = m_seen[i];
            q.push_back('{i, m_seen[i]});
          end
        end
      end
      for (int i = 0; i < N; i++) m_seen[i] = int'(interrupts[i]);
    end
  end

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  bit     prev_stall = 0;
  longint prev_addr  = 0;
  longint prev_data  = 0;

  always @(negedge clk) begin
    exp_t e;
    chk("valid", longint'(bus.valid), longint'(m_busy));
    chk("action", longint'(bus.action), longint'(ACTION_INTERRUPT));
    if (!rst_n) begin
      chk("rst_addr", longint'(bus.address), 0);
      chk("rst_data", longint'(bus.data), 0);
      prev_stall = 0;
    end else begin
      if (prev_stall && bus.valid) begin
        chk("hold_addr", longint'(bus.address), prev_addr);
        chk("hold_data", longint'(bus.data), prev_data);
      end
      if (bus.valid && bus.ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty: got addr %0d, expected no message",
                   bus.address);
        end else begin
          e = q.pop_front();
          chk("msg_addr", longint'(bus.address), longint'(e.line));
          chk("msg_data", longint'(bus.data), longint'(e.lvl));
        end
        log_q.push_back(int'(bus.address) * 2 + int'(bus.data[0]));
      end
      prev_stall = bus.valid && !bus.ready;
      prev_addr  = longint'(bus.address);
      prev_data  = longint'(bus.data);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Log entries are line*2+level.
  task automatic chk_log(string name, int n, int e0, int e1, int e2);
    int ex[3];
    ex[0] = e0;
    ex[1] = e1;
    ex[2] = e2;
    chk({name, "_count"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++)
      chk({name, "_entry"}, log_q[i], ex[i]);
  endtask

  initial begin
    bus.ready = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    chk_log("idle", 0, 0, 0, 0);

    log_q.delete();
    interrupts = 4'b0100;
    cyc(6);
    interrupts = 4'b0000;
    cyc(6);
    chk_log("line2", 2, 5, 4, 0);

    log_q.delete();
    interrupts = 4'b1011;
    cyc(10);
    chk_log("multi", 3, 1, 3, 7);
    interrupts = 4'b0000;
    cyc(10);

    log_q.delete();
    bus.ready = 1'b0;
    interrupts = 4'b0010;
    cyc(5);
    interrupts = 4'b0000;
    cyc(5);
    bus.ready = 1'b1;
    cyc(8);
    chk_log("stall", 2, 3, 2, 0);

    log_q.delete();
    bus.ready = 1'b0;
    interrupts = 4'b1000;
    cyc(3);
    interrupts = 4'b1001;
    cyc(1);
    interrupts = 4'b1000;
    cyc(3);
    bus.ready = 1'b1;
    cyc(6);
    chk_log("glitch", 1, 7, 0, 0);

    bus.ready = 1'b0;
    interrupts = 4'b0001;
    cyc(4);
    rst_n = 1'b0;
    cyc(2);
    log_q.delete();
    rst_n = 1'b1;
    bus.ready = 1'b1;
    cyc(8);
    chk_log("reset", 1, 1, 0, 0);

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0)
        interrupts[$urandom_range(0, N - 1)] ^= 1'b1;
      bus.ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end

    bus.ready = 1'b1;
    cyc(20);
    chk("drain_queue", q.size(), 0);
    chk("drain_valid", longint'(bus.valid), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
